fifo_mac: RTL and testbench
===========================

# fifo_mac

Downstream consumer of the MMIO write FIFO in the `ccip_mmio` AFU. It accepts 64-bit words through a valid/ready handshake and treats each word as two signed 32-bit operands. It multiplies the pair and accumulates the products over a batch of `DEPTH` words. The 64-bit result and its status are exposed for the AFU's MMIO read mux.

## Interface
- `DEPTH`, 8: words per batch, range 1 to 255.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a batch.
- `clr` input 1: synchronous abort; returns the block to IDLE.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input 64: operand A is `[63:32]`, operand B is `[31:0]`, both signed two's complement.
- `in_ready` output 1: block accepts a beat this cycle.
- `acc` output 64: signed accumulator.
- `beat_cnt` output 8: beats accepted in the current batch.
- `busy` output 1: state is ACCUM or DRAIN.
- `done` output 1: batch complete; `acc` is final.
- `ovf` output 1: sticky signed-overflow flag.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE or DONE:
  - `start` clears `acc`, `beat_cnt`, `ovf` and the product-valid flag, then moves to ACCUM.
- ACCUM:
  - `in_ready` is 1.
  - A beat is accepted when `in_valid & in_ready`; each accepted beat increments `beat_cnt`.
  - On accepting beat number `DEPTH`, move to DRAIN. `in_ready` is 0 from then on.
- DRAIN: after one cycle, move to DONE.
- DONE:
  - `done` is 1.
  - `acc`, `beat_cnt` and `ovf` hold until `start` or `clr`.
- `in_ready` is 0 in every state except ACCUM.
- `start` is ignored in ACCUM and DRAIN.
- `clr` in any state:
  - moves to IDLE;
  - zeroes `acc`, `beat_cnt`, `ovf` and the product register;
  - drops any in-flight product.
  - `clr` wins over a simultaneous `start`.
- Arithmetic:
  - Product is the signed 32x32 result, 64 bits, exact.
  - Accumulate is a 64-bit signed add.
  - Overflow: both addends have the same sign and the sum's sign differs. Overflow sets `ovf`.
- Reset: state IDLE; `acc`, `beat_cnt`, `ovf`, `busy`, `done`, `in_ready` and the product register are all 0. Reset mid-batch discards everything.

## Timing
- Pipeline:
  - A beat accepted at edge E registers its product at E.
  - The product is added into `acc` at E+1.
  - `ovf` updates at E+1.
- Last beat accepted at edge E:
  - DRAIN at E.
  - DONE, with final `acc` and `done`=1, at E+1.
  - `done` is visible in the cycle after E+1, i.e. 2 cycles after the last beat.
- Throughput is one beat per cycle; no bubbles are required.
- `in_valid` gaps stall the count only. A product is added only when its valid flag is set.
- `start` at edge S:
  - ACCUM from S.
  - `in_ready`=1 from the cycle after S.
  - `done` falls at S.
- `busy` and `done` are decoded directly from state registers, with no combinational input paths.

## Configuration
- `FIFO_MAC_SAT_EN` defined:
  - On overflow, `acc` saturates to 0x7FFF_FFFF_FFFF_FFFF for positive overflow or 0x8000_0000_0000_0000 for negative overflow.
  - Accumulation continues from the saturated value.
  - `ovf` is still set.
- Not defined: `acc` wraps modulo 2^64 and `ovf` is set.

## Structure
- Shared package `fifo_mac_pkg` holds:
  - state enum `t_mac_state`;
  - `MAC_W`=64 and `OP_W`=32;
  - saturation constants `ACC_MAX` and `ACC_MIN`.
- One sub-module, `mac_mult_stage`: signed multiplier plus the product and product-valid registers, with a synchronous clear input. FSM, counter and accumulator stay in `fifo_mac`.

## Test plan
- `DEPTH`=8; `start`; 8 back-to-back beats of A=3, B=4:
  - `acc`=96, `beat_cnt`=8;
  - `done` high 2 cycles after the 8th beat;
  - `ovf`=0.
- 8 beats of A=-2 (0xFFFFFFFE), B=5, with `in_valid` low on alternate cycles: `acc`=-80 (0xFFFF_FFFF_FFFF_FFB0), `in_ready` low in DRAIN and DONE.
- Two beats of A=B=0x80000000, rest 0:
  - without the macro: `acc`=0x8000_0000_0000_0000, `ovf`=1;
  - with `FIFO_MAC_SAT_EN`: `acc`=0x7FFF_FFFF_FFFF_FFFF, `ovf`=1.
- `clr` after 4 beats of A=1, B=1: next cycle IDLE, `acc`=0, `beat_cnt`=0, `busy`=0. A following `start` plus 8 beats of 1x1 gives `acc`=8.
- `rst_n` low asynchronously mid-batch: all outputs 0 immediately. `start` pulsed in ACCUM is ignored, and `start` with `clr` in the same cycle leaves the block in IDLE.

Source files
------------

// File: rtl/fifo_mac_pkg.sv
// fifo_mac_pkg
// Shared definitions for the fifo_mac multiply-accumulate block:
//   t_mac_state : batch FSM state encoding
//   MAC_W/OP_W  : accumulator and operand widths
//   ACC_MAX/MIN : signed saturation limits of the accumulator
//   add_ovf     : signed-add overflow detector
package fifo_mac_pkg;

  localparam int MAC_W = 64;
  localparam int OP_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_mac_state;

  localparam logic [MAC_W-1:0] ACC_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [MAC_W-1:0] ACC_MIN = 64'h8000_0000_0000_0000;

  // Overflow of a + b: both addends share a sign and the sum's sign differs.
  function automatic logic add_ovf(input logic [MAC_W-1:0] a,
                                   input logic [MAC_W-1:0] b,
                                   input logic [MAC_W-1:0] sum);
    return (a[MAC_W-1] == b[MAC_W-1]) && (sum[MAC_W-1] != a[MAC_W-1]);
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage
// Signed 32x32 -> 64 multiplier with a registered product and product-valid flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of product and valid flag (wins over load)
//   load       : an operand pair was accepted this cycle
//   op_a, op_b : signed operands
//   prod       : registered exact product
//   prod_vld   : prod holds a product not yet accumulated
module mac_mult_stage
  import fifo_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [MAC_W-1:0] prod,
  output logic             prod_vld
);

  logic signed [MAC_W-1:0] mult_s;
  logic        [MAC_W-1:0] prod_r;
  logic                    prod_vld_r;

  // Exact signed product; operands are sign-extended to the 64-bit context.
  always_comb begin
    mult_s = $signed(op_a) * $signed(op_b);
  end

  // Product register: loads on an accepted beat, valid flag lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r     <= 64'd0;
      prod_vld_r <= 1'b0;
    end else if (clr) begin
      prod_r     <= 64'd0;
      prod_vld_r <= 1'b0;
    end else if (load) begin
      prod_r     <= mult_s;
      prod_vld_r <= 1'b1;
    end else begin
      prod_vld_r <= 1'b0;
    end
  end

  assign prod     = prod_r;
  assign prod_vld = prod_vld_r;

endmodule

// File: rtl/fifo_mac.sv
// fifo_mac
// Consumes 64-bit words from the MMIO write FIFO, multiplies the two signed
// 32-bit halves and accumulates DEPTH products per batch.
// Optional feature: define FIFO_MAC_SAT_EN to saturate acc on overflow
// (otherwise acc wraps modulo 2^64). ovf is sticky in both builds.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse, begins a batch from IDLE or DONE
//   clr        : synchronous abort to IDLE, wins over start
//   in_valid   : in_data valid
//   in_data    : {A[63:32], B[31:0]} signed operands
//   in_ready   : high only in ACCUM
//   acc        : signed accumulator
//   beat_cnt   : beats accepted in the current batch
//   busy       : ACCUM or DRAIN
//   done       : batch complete, acc final
//   ovf        : sticky signed-overflow flag
module fifo_mac
  import fifo_mac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic [63:0] acc,
  output logic [7:0]  beat_cnt,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam logic [7:0] LAST_CNT = 8'(DEPTH - 1);

  t_mac_state       state_r;
  t_mac_state       state_nxt_s;
  logic [MAC_W-1:0] acc_r;
  logic [7:0]       beat_cnt_r;
  logic             ovf_r;

  logic             accept_s;
  logic             start_go_s;
  logic             mult_clr_s;
  logic [MAC_W-1:0] prod_s;
  logic             prod_vld_s;
  logic [MAC_W-1:0] sum_s;
  logic             add_ovf_s;
  logic [MAC_W-1:0] acc_upd_s;

  // Beat acceptance and batch start qualification; clr suppresses both.
  always_comb begin
    accept_s   = in_valid && (state_r == ST_ACCUM) && !clr;
    start_go_s = start && !clr && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    mult_clr_s = clr || start_go_s;
  end

  mac_mult_stage u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mult_clr_s),
    .load     (accept_s),
    .op_a     (in_data[63:32]),
    .op_b     (in_data[31:0]),
    .prod     (prod_s),
    .prod_vld (prod_vld_s)
  );

  // Next-state logic for the batch FSM.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) state_nxt_s = ST_ACCUM;
          else       state_nxt_s = state_r;
        end
        ST_ACCUM: begin
          if (accept_s && (beat_cnt_r == LAST_CNT)) state_nxt_s = ST_DRAIN;
          else                                      state_nxt_s = ST_ACCUM;
        end
        ST_DRAIN: state_nxt_s = ST_DONE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Accumulator update value including overflow handling.
  always_comb begin
    sum_s     = acc_r + prod_s;
    add_ovf_s = add_ovf(acc_r, prod_s, sum_s);
`ifdef FIFO_MAC_SAT_EN
    if (add_ovf_s) begin
      // Both addends share a sign; a negative product means negative overflow.
      if (prod_s[MAC_W-1]) acc_upd_s = ACC_MIN;
      else                 acc_upd_s = ACC_MAX;
    end else begin
      acc_upd_s = sum_s;
    end
`else
    acc_upd_s = sum_s;
`endif
  end

  // Accumulator, beat counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= 64'd0;
      beat_cnt_r <= 8'd0;
      ovf_r      <= 1'b0;
    end else if (clr || start_go_s) begin
      acc_r      <= 64'd0;
      beat_cnt_r <= 8'd0;
      ovf_r      <= 1'b0;
    end else begin
      if (accept_s) beat_cnt_r <= beat_cnt_r + 8'd1;
      if (prod_vld_s) begin
        acc_r <= acc_upd_s;
        if (add_ovf_s) ovf_r <= 1'b1;
      end
    end
  end

  assign acc      = acc_r;
  assign beat_cnt = beat_cnt_r;
  assign ovf      = ovf_r;
  assign in_ready = (state_r == ST_ACCUM);
  assign busy     = (state_r == ST_ACCUM) || (state_r == ST_DRAIN);
  assign done     = (state_r == ST_DONE);

endmodule

// File: tb/tb_fifo_mac.sv
module tb_fifo_mac;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic [63:0] acc;
  logic [7:0]  beat_cnt;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_cmp;
  int n_err;

  logic [31:0] a_arr [8];
  logic [31:0] b_arr [8];

  fifo_mac #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .acc      (acc),
    .beat_cnt (beat_cnt),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: exact running sum in 128 bits, range-checked against the
  // signed 64-bit limits after every product.
  task automatic model(output logic [63:0] e_acc, output logic e_ovf);
    logic signed [127:0] s;
    logic signed [127:0] p;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    max_v = 128'sd9223372036854775807;
    min_v = -max_v - 128'sd1;
    s = 128'sd0;
    e_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = 128'($signed(a_arr[i])) * 128'($signed(b_arr[i]));
      s = s + p;
      if (s > max_v || s < min_v) begin
        e_ovf = 1'b1;
`ifdef FIFO_MAC_SAT_EN
        if (s > max_v) s = max_v;
        else           s = min_v;
`else
        s = 128'($signed(s[63:0]));
`endif
      end
    end
    e_acc = s[63:0];
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = a;
      b_arr[i] = b;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full batch from the arrays; optional random in_valid gaps and an
  // optional start pulse alongside beat index mid_start (must be ignored).
  task automatic run_batch(input string tag, input bit gaps, input int mid_start,
                           output logic [63:0] e_acc);
    logic e_ovf;
    int   i;
    int   n_gap;
    model(e_acc, e_ovf);
    pulse_start();
    chk({tag, "_start_busy"}, 64'(busy), 64'd1);
    chk({tag, "_start_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_start_done"}, 64'(done), 64'd0);
    chk({tag, "_start_acc"}, acc, 64'd0);
    i = 0;
    n_gap = 0;
    while (i < 8) begin
      if (gaps && n_gap < 8 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        n_gap++;
      end else begin
        in_valid = 1'b1;
        in_data  = {a_arr[i], b_arr[i]};
        if (i == mid_start) start = 1'b1;
        i++;
      end
      @(negedge clk);
      start = 1'b0;
      if (i == mid_start + 1) chk({tag, "_midstart_cnt"}, 64'(beat_cnt), 64'(i));
    end
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    chk({tag, "_drain_busy"}, 64'(busy), 64'd1);
    chk({tag, "_drain_rdy"}, 64'(in_ready), 64'd0);
    chk({tag, "_drain_done"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done_rdy"}, 64'(in_ready), 64'd0);
    chk({tag, "_acc"}, acc, e_acc);
    chk({tag, "_cnt"}, 64'(beat_cnt), 64'd8);
    chk({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_hold_acc"}, acc, e_acc);
    chk({tag, "_hold_cnt"}, 64'(beat_cnt), 64'd8);
  endtask

  logic [63:0] res;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 64'd0;
    #1;
    chk("rst_acc", acc, 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 x 4, back to back.
    fill(32'd3, 32'd4);
    run_batch("b34", 1'b0, -1, res);
    chk("b34_const", res, 64'd96);

    // -2 x 5 with in_valid gaps.
    fill(32'hFFFF_FFFE, 32'd5);
    run_batch("bneg", 1'b1, -1, res);
    chk("bneg_const", res, 64'hFFFF_FFFF_FFFF_FFB0);

    // Two 2^62 products overflow the positive range.
    fill(32'd0, 32'd0);
    a_arr[0] = 32'h8000_0000; b_arr[0] = 32'h8000_0000;
    a_arr[1] = 32'h8000_0000; b_arr[1] = 32'h8000_0000;
    run_batch("bovf", 1'b0, -1, res);
`ifdef FIFO_MAC_SAT_EN
    chk("bovf_const", res, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("bovf_const", res, 64'h8000_0000_0000_0000);
`endif
    chk("bovf_flag", 64'(ovf), 64'd1);

    // Randomized batches, some with extreme operands to force overflow.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (k >= 3) begin
          a_arr[i] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          b_arr[i] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          a_arr[i] = $urandom;
          b_arr[i] = $urandom;
        end
      end
      run_batch($sformatf("rnd%0d", k), 1'(k % 2), -1, res);
    end

    // start pulsed in ACCUM is ignored.
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = $urandom_range(0, 1000);
      b_arr[i] = $urandom_range(0, 1000);
    end
    run_batch("midst", 1'b0, 3, res);

    // clr after 4 beats of 1 x 1.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {32'd1, 32'd1};
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_clr_cnt", 64'(beat_cnt), 64'd4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_acc", acc, 64'd0);
    chk("clr_cnt", 64'(beat_cnt), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("clr_acc_late", acc, 64'd0);
    fill(32'd1, 32'd1);
    run_batch("after_clr", 1'b0, -1, res);
    chk("after_clr_const", res, 64'd8);

    // start together with clr from DONE stays in IDLE.
    start = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    chk("stclr_busy", 64'(busy), 64'd0);
    chk("stclr_done", 64'(done), 64'd0);
    chk("stclr_acc", acc, 64'd0);
    @(negedge clk);
    chk("stclr_rdy", 64'(in_ready), 64'd0);

    // Asynchronous reset mid-batch.
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {32'd7, 32'd9};
      @(negedge clk);
    end
    chk("prerst_acc", acc, 64'd126);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", acc, 64'd0);
    chk("arst_cnt", 64'(beat_cnt), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_acc", acc, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
